// File: rtl/mac_pkg.sv
// Shared definitions for the MAC sequencer: FSM state encoding and data widths.
package mac_pkg;
  localparam int ACC_W  = 16;
  localparam int OPND_W = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INIT    = 3'd1,
    ISSUE   = 3'd2,
    DRAIN   = 3'd3,
    CAPTURE = 3'd4,
    HOLD    = 3'd5
  } state_e;
endpackage

// File: rtl/mac_valid_pipe.sv
// Valid shift register tracking operand reads through memory and multiplier latency.
module mac_valid_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din_i,
  output logic dout_o,
  output logic pending_o
);
  logic [DEPTH-1:0] pipe_q;
  logic [DEPTH-1:0] pipe_d;

  // pending_o ignores the output stage: it says whether anything is still on its way to dout_o.
  generate
    if (DEPTH == 1) begin : g_one
      assign pipe_d    = din_i;
      assign pending_o = 1'b0;
    end else begin : g_multi
      assign pipe_d    = {pipe_q[DEPTH-2:0], din_i};
      assign pending_o = |pipe_q[DEPTH-2:0];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pipe_q <= '0;
    else     pipe_q <= pipe_d;
  end

  assign dout_o = pipe_q[DEPTH-1];
endmodule

// File: rtl/mac_sequencer.sv
// Sequences one MAC job: bias load, N_TERMS operand reads, pipeline drain, result handshake.
// Handshake: result_valid stays high with result stable until a cycle where result_ready is also high.
module mac_sequencer
  import mac_pkg::*;
#(
  parameter int N_TERMS  = 9,
  parameter int ADDR_W   = 4,
  parameter int MULT_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [OPND_W-1:0] bias,
  input  logic [ADDR_W-1:0] a_base,
  input  logic [ADDR_W-1:0] b_base,
  output logic              busy,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] a_addr,
  output logic [ADDR_W-1:0] b_addr,
  input  logic [OPND_W-1:0] a_rdata,
  input  logic [OPND_W-1:0] b_rdata,
  output logic [OPND_W-1:0] mac_a,
  output logic [OPND_W-1:0] mac_b,
  output logic [OPND_W-1:0] mac_bias,
  output logic              mac_init,
  output logic              mac_ld,
  input  logic [ACC_W-1:0]  mac_acc,
  output logic [ACC_W-1:0]  result,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [2:0]        dbg_state
);
  localparam int D  = 1 + MULT_LAT;
  localparam int KW = $clog2(N_TERMS + 1);
  localparam logic [KW-1:0] K_LAST = KW'(N_TERMS - 1);

  state_e            state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [OPND_W-1:0] bias_q, bias_d;
  logic [ADDR_W-1:0] a_base_q, a_base_d;
  logic [ADDR_W-1:0] b_base_q, b_base_d;
  logic [ACC_W-1:0]  result_q, result_d;
  logic              pipe_pending;

  mac_valid_pipe #(.DEPTH(D)) u_valid_pipe (
    .clk       (clk),
    .rst       (rst),
    .din_i     (mem_rd),
    .dout_o    (mac_ld),
    .pending_o (pipe_pending)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      k_q      <= '0;
      bias_q   <= '0;
      a_base_q <= '0;
      b_base_q <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      bias_q   <= bias_d;
      a_base_q <= a_base_d;
      b_base_q <= b_base_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    bias_d       = bias_q;
    a_base_d     = a_base_q;
    b_base_d     = b_base_q;
    result_d     = result_q;
    mem_rd       = 1'b0;
    mac_init     = 1'b0;
    result_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = INIT;
          bias_d   = bias;
          a_base_d = a_base;
          b_base_d = b_base;
          k_d      = '0;
        end
      end
      INIT: begin
        mac_init = 1'b1;
        state_d  = ISSUE;
      end
      ISSUE: begin
        mem_rd = 1'b1;
        // k stops at its last value so the addresses hold after the job.
        if (k_q == K_LAST) state_d = DRAIN;
        else               k_d     = k_q + KW'(1);
      end
      DRAIN: begin
        // Leave when only the final accumulate is left; it lands before CAPTURE samples.
        if (!pipe_pending) state_d = CAPTURE;
      end
      CAPTURE: begin
        result_d = mac_acc;
        state_d  = HOLD;
      end
      HOLD: begin
        result_valid = 1'b1;
        if (result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign a_addr    = a_base_q + ADDR_W'(k_q);
  assign b_addr    = b_base_q + ADDR_W'(k_q);
  assign mac_a     = a_rdata;
  assign mac_b     = b_rdata;
  assign mac_bias  = bias_q;
  assign result    = result_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer with behavioural sync-read memories and sign-magnitude MAC.
module tb_mac_sequencer;
  logic clk, rst;
  int total = 0;
  int bad = 0;

  // instance 0: N_TERMS=9, MULT_LAT=1
  logic       start0, result_ready0, busy0, mem_rd0, mac_init0, mac_ld0, result_valid0;
  logic [7:0] bias0, a_rdata0, b_rdata0, mac_a0, mac_b0, mac_bias0;
  logic [3:0] a_base0, b_base0, a_addr0, b_addr0;
  logic [15:0] acc0, prod0, result0;
  logic [2:0] dbg0;
  logic [7:0] mem_a0 [16];
  logic [7:0] mem_b0 [16];

  // instance 1: N_TERMS=1, MULT_LAT=0
  logic       start1, result_ready1, busy1, mem_rd1, mac_init1, mac_ld1, result_valid1;
  logic [7:0] bias1, a_rdata1, b_rdata1, mac_a1, mac_b1, mac_bias1;
  logic [3:0] a_base1, b_base1, a_addr1, b_addr1;
  logic [15:0] acc1, result1;
  logic [2:0] dbg1;
  logic [7:0] mem_a1 [16];
  logic [7:0] mem_b1 [16];

  mac_sequencer #(.N_TERMS(9), .ADDR_W(4), .MULT_LAT(1)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .bias(bias0), .a_base(a_base0), .b_base(b_base0),
    .busy(busy0), .mem_rd(mem_rd0), .a_addr(a_addr0), .b_addr(b_addr0),
    .a_rdata(a_rdata0), .b_rdata(b_rdata0), .mac_a(mac_a0), .mac_b(mac_b0),
    .mac_bias(mac_bias0), .mac_init(mac_init0), .mac_ld(mac_ld0), .mac_acc(acc0),
    .result(result0), .result_valid(result_valid0), .result_ready(result_ready0),
    .dbg_state(dbg0)
  );

  mac_sequencer #(.N_TERMS(1), .ADDR_W(4), .MULT_LAT(0)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .bias(bias1), .a_base(a_base1), .b_base(b_base1),
    .busy(busy1), .mem_rd(mem_rd1), .a_addr(a_addr1), .b_addr(b_addr1),
    .a_rdata(a_rdata1), .b_rdata(b_rdata1), .mac_a(mac_a1), .mac_b(mac_b1),
    .mac_bias(mac_bias1), .mac_init(mac_init1), .mac_ld(mac_ld1), .mac_acc(acc1),
    .result(result1), .result_valid(result_valid1), .result_ready(result_ready1),
    .dbg_state(dbg1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] sm_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] m;
    m = 16'(a[6:0]) * 16'(b[6:0]);
    return (a[7] ^ b[7]) ? (16'd0 - m) : m;
  endfunction

  function automatic logic [15:0] sm_ext(input logic [7:0] v);
    logic [15:0] m;
    m = 16'(v[6:0]);
    return v[7] ? (16'd0 - m) : m;
  endfunction

  always @(posedge clk) begin
    if (mem_rd0) begin a_rdata0 <= mem_a0[a_addr0]; b_rdata0 <= mem_b0[b_addr0]; end
    if (mem_rd1) begin a_rdata1 <= mem_a1[a_addr1]; b_rdata1 <= mem_b1[b_addr1]; end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      prod0 <= '0; acc0 <= '0; acc1 <= '0;
    end else begin
      prod0 <= sm_mul(mac_a0, mac_b0);
      if (mac_init0)    acc0 <= sm_ext(mac_bias0);
      else if (mac_ld0) acc0 <= acc0 + prod0;
      if (mac_init1)    acc1 <= sm_ext(mac_bias1);
      else if (mac_ld1) acc1 <= acc1 + sm_mul(mac_a1, mac_b1);
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // per-job observations of instance 0
  int ld_first, ld_last, ld_cnt, rd_cnt, rv_first, rv_cnt, init_cnt, init_cyc;
  logic overlap, res_unstable, done;
  logic [15:0] res_first;
  logic [3:0] a_seen [16];
  logic [3:0] b_seen [16];

  // smode: 0 drop start after cycle 1, 1 keep start high, 2 toggle start during HOLD
  task automatic job0(input logic [7:0] b, input logic [3:0] ab, input logic [3:0] bb,
                      input int rdy_dly, input int smode);
    start0 = 1'b1; bias0 = b; a_base0 = ab; b_base0 = bb;
    result_ready0 = (rdy_dly == 0);
    ld_first = -1; ld_last = -1; ld_cnt = 0; rd_cnt = 0; rv_first = -1; rv_cnt = 0;
    init_cnt = 0; init_cyc = -1; overlap = 1'b0; res_unstable = 1'b0; done = 1'b0;
    @(posedge clk);
    for (int c = 1; c <= 60 && !done; c++) begin
      @(negedge clk);
      if (c == 1 && smode != 1) start0 = 1'b0;
      if (mac_ld0) begin if (ld_first < 0) ld_first = c; ld_last = c; ld_cnt++; end
      if (mem_rd0) begin
        if (rd_cnt < 16) begin a_seen[rd_cnt] = a_addr0; b_seen[rd_cnt] = b_addr0; end
        rd_cnt++;
      end
      if (mac_init0) begin init_cnt++; init_cyc = c; end
      if (mac_init0 && mac_ld0) overlap = 1'b1;
      if (result_valid0) begin
        if (rv_first < 0) begin rv_first = c; res_first = result0; end
        else if (result0 !== res_first) res_unstable = 1'b1;
        if (rv_cnt >= rdy_dly) result_ready0 = 1'b1;
        if (smode == 2) start0 = ((rdy_dly - rv_cnt) % 2 == 0);
        rv_cnt++;
        if (result_ready0) done = 1'b1;
      end
    end
    check_val("job_timeout", {31'd0, done}, 32'd1);
    @(posedge clk);
    #1;
    result_ready0 = 1'b0;
    if (smode == 2) start0 = 1'b0;
  endtask

  int ld1_first, ld1_cnt, rv1_first;
  logic [15:0] res1;
  logic done1;

  task automatic job1(input logic [7:0] b);
    start1 = 1'b1; bias1 = b; a_base1 = 4'd0; b_base1 = 4'd0; result_ready1 = 1'b1;
    ld1_first = -1; ld1_cnt = 0; rv1_first = -1; done1 = 1'b0; res1 = '0;
    @(posedge clk);
    for (int c = 1; c <= 30 && !done1; c++) begin
      @(negedge clk);
      if (c == 1) start1 = 1'b0;
      if (mac_ld1) begin if (ld1_first < 0) ld1_first = c; ld1_cnt++; end
      if (result_valid1) begin rv1_first = c; res1 = result1; done1 = 1'b1; end
    end
    check_val("t6_timeout", {31'd0, done1}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  int rv_seen;
  logic any_busy;

  initial begin
    rst = 1'b1;
    start0 = 1'b0; bias0 = '0; a_base0 = '0; b_base0 = '0; result_ready0 = 1'b0;
    start1 = 1'b0; bias1 = '0; a_base1 = '0; b_base1 = '0; result_ready1 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mem_a0[i] = 8'h02; mem_b0[i] = 8'h03; mem_a1[i] = 8'h07; mem_b1[i] = 8'h07;
    end
    repeat (3) @(negedge clk);
    check_val("rst_busy", {31'd0, busy0}, 32'd0);
    check_val("rst_mem_rd", {31'd0, mem_rd0}, 32'd0);
    check_val("rst_init_ld", {30'd0, mac_init0, mac_ld0}, 32'd0);
    check_val("rst_valid", {31'd0, result_valid0}, 32'd0);
    check_val("rst_result", {16'd0, result0}, 32'd0);
    check_val("rst_addr", {24'd0, a_addr0, b_addr0}, 32'd0);
    check_val("rst_state", {29'd0, dbg0}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: basic job, bias 5, A=2 B=3 -> 5 + 9*6 = 59
    job0(8'd5, 4'd0, 4'd0, 0, 0);
    check_val("t1_result", {16'd0, res_first}, 32'h003B);
    check_val("t1_rv_first", rv_first, 14);
    check_val("t1_rv_cnt", rv_cnt, 1);
    check_val("t1_ld_first", ld_first, 4);
    check_val("t1_ld_last", ld_last, 12);
    check_val("t1_ld_cnt", ld_cnt, 9);
    check_val("t1_init", {init_cnt[15:0], init_cyc[15:0]}, {16'd1, 16'd1});
    check_val("t1_overlap", {31'd0, overlap}, 32'd0);
    check_val("t1_bias", {24'd0, mac_bias0}, 32'd5);
    @(negedge clk);
    check_val("t1_idle", {31'd0, busy0}, 32'd0);

    // 2: address wrap from bases 14 / 15
    job0(8'd5, 4'hE, 4'hF, 0, 0);
    check_val("t2_rd_cnt", rd_cnt, 9);
    for (int i = 0; i < 9; i++) begin
      check_val($sformatf("t2_a%0d", i), {28'd0, a_seen[i]}, (14 + i) % 16);
      check_val($sformatf("t2_b%0d", i), {28'd0, b_seen[i]}, (15 + i) % 16);
    end
    check_val("t2_result", {16'd0, res_first}, 32'h003B);
    @(negedge clk);
    check_val("t2_addr_hold", {24'd0, a_addr0, b_addr0}, {24'd0, 4'd6, 4'd7});

    // 3: consumer stalls 5 HOLD cycles while start toggles
    job0(8'd5, 4'd0, 4'd0, 5, 2);
    check_val("t3_rv_cnt", rv_cnt, 6);
    check_val("t3_stable", {31'd0, res_unstable}, 32'd0);
    check_val("t3_result", {16'd0, res_first}, 32'h003B);
    check_val("t3_init_cnt", init_cnt, 1);
    any_busy = 1'b0;
    repeat (3) begin @(negedge clk); any_busy = any_busy | busy0; end
    check_val("t3_no_restart", {31'd0, any_busy}, 32'd0);

    // 4: reset in the middle of ISSUE
    start0 = 1'b1; bias0 = 8'd9; a_base0 = 4'd3; b_base0 = 4'd4;
    @(posedge clk);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1) start0 = 1'b0;
    end
    check_val("t4_in_issue", {31'd0, mem_rd0}, 32'd1);
    rst = 1'b1;
    #1;
    check_val("t4_busy", {31'd0, busy0}, 32'd0);
    check_val("t4_mem_rd", {31'd0, mem_rd0}, 32'd0);
    check_val("t4_ld", {31'd0, mac_ld0}, 32'd0);
    check_val("t4_addr", {24'd0, a_addr0, b_addr0}, 32'd0);
    check_val("t4_bias", {24'd0, mac_bias0}, 32'd0);
    check_val("t4_result", {15'd0, result_valid0, result0}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    rv_seen = 0;
    repeat (20) begin @(negedge clk); if (result_valid0 || busy0) rv_seen++; end
    check_val("t4_quiet", rv_seen, 0);
    job0(8'd5, 4'd0, 4'd0, 0, 0);
    check_val("t4_clean_result", {16'd0, res_first}, 32'h003B);
    check_val("t4_clean_rv", rv_first, 14);
    @(negedge clk);

    // 5: back-to-back, bias 0 with A=0, start held high through the first job
    for (int i = 0; i < 16; i++) mem_a0[i] = 8'h00;
    job0(8'd0, 4'd0, 4'd0, 0, 1);
    check_val("t5_result0", {16'd0, res_first}, 32'h0000);
    check_val("t5_init_cnt", init_cnt, 1);
    check_val("t5_rv_first", rv_first, 14);
    @(negedge clk);
    check_val("t5_idle_gap", {28'd0, busy0, dbg0}, 32'd0);
    job0(8'd0, 4'd0, 4'd0, 0, 0);
    check_val("t5_result1", {16'd0, res_first}, 32'h0000);
    check_val("t5_rv_first1", rv_first, 14);

    // 6: N_TERMS=1, MULT_LAT=0 -> 1 + 49 = 50
    @(negedge clk);
    job1(8'd1);
    check_val("t6_result", {16'd0, res1}, 32'h0032);
    check_val("t6_ld_first", ld1_first, 3);
    check_val("t6_ld_cnt", ld1_cnt, 1);
    check_val("t6_rv_first", rv1_first, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
